// File: rtl/baseaddr_pkg.sv
// Shared definitions for the frame-buffer pointer loop: ring size, one-hot
// pointer type, pointer helpers and the reader FSM encoding.
package baseaddr_pkg;

    localparam int NBUF = 5;

    typedef logic [NBUF-1:0] onehot_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } rd_state_t;

    // True when exactly one bit of the pointer is set.
    function automatic logic onehot_valid(input onehot_t v);
        return (v != '0) && ((v & (v - onehot_t'(1))) == '0);
    endfunction

    // Position of the set bit; an all-zero pointer maps to 0.
    function automatic logic [2:0] onehot2idx(input onehot_t v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NBUF; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/edge_generator.sv
// Registered edge detector producing a one-cycle pulse on the selected edge
// of an already-synchronous input.
module edge_generator #(
    parameter string MODE = "NORMAL"
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic pulse_out
);

    logic prev_q, prev_d;
    logic pulse_q, pulse_d;

    // Edge selection: NORMAL = rising, FALLING = falling, BOTH = either.
    always_comb begin
        prev_d = sig_in;
        if (MODE == "FALLING") begin
            pulse_d = prev_q & ~sig_in;
        end else if (MODE == "BOTH") begin
            pulse_d = prev_q ^ sig_in;
        end else begin
            pulse_d = sig_in & ~prev_q;
        end
    end

    // Previous-value and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign pulse_out = pulse_q;

endmodule

// File: rtl/baseaddr_rd_loop.sv
// Reader-side buffer pointer tracker: adopts the writer's newest completed
// buffer on each reader vsync and reports its pointer and DDR base address.
module baseaddr_rd_loop
    import baseaddr_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] FRAME_BYTES = 32'h0020_0000,
    parameter int          ADDR_W      = 32
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              rd_vs,
    input  logic              rd_en,
    input  logic [NBUF-1:0]   wr_current_point,
    input  logic [NBUF-1:0]   last_next_point,
    output logic [NBUF-1:0]   rd_curr_point,
    output logic [ADDR_W-1:0] rd_base_addr,
    output logic              rd_frame_valid,
    output logic              rd_frame_new,
    output logic [7:0]        repeat_cnt,
    output logic [7:0]        skip_cnt
);

    localparam logic [ADDR_W-1:0] BASE_W  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] FRAME_W = ADDR_W'(FRAME_BYTES);

    logic vs_sync1_q, vs_sync1_d;
    logic vs_sync2_q, vs_sync2_d;
    logic vs_rise_s;

    rd_state_t         state_q, state_d;
    onehot_t           curr_q, curr_d;
    onehot_t           lnp_q, lnp_d;
    logic              pending_q, pending_d;
    logic [7:0]        repeat_q, repeat_d;
    logic [7:0]        skip_q, skip_d;
    logic              valid_q, valid_d;
    logic              new_q, new_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic lnp_change_s;
    logic adopt_s;
    logic repeat_inc_s;
    logic can_adopt_s;

    // Two-stage synchronizer for the reader vsync.
    always_comb begin
        vs_sync1_d = rd_vs;
        vs_sync2_d = vs_sync1_q;
    end

    edge_generator #(
        .MODE ("NORMAL")
    ) u_vs_edge (
        .clk       (wclk),
        .rst_n     (wrst_n),
        .sig_in    (vs_sync2_q),
        .pulse_out (vs_rise_s)
    );

    // Adoption FSM and pointer selection; uses the pre-update shadow/pending.
    always_comb begin
        state_d      = state_q;
        curr_d       = curr_q;
        adopt_s      = 1'b0;
        repeat_inc_s = 1'b0;
        can_adopt_s  = pending_q && (lnp_q != wr_current_point);
        case (state_q)
            ST_IDLE: begin
                if (vs_rise_s && rd_en && can_adopt_s) begin
                    adopt_s = 1'b1;
                end else begin
                    adopt_s = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (vs_rise_s) begin
                    if (!rd_en) begin
                        state_d = ST_IDLE;
                        curr_d  = '0;
                    end else if (can_adopt_s) begin
                        adopt_s = 1'b1;
                    end else begin
                        repeat_inc_s = 1'b1;
                    end
                end else begin
                    repeat_inc_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                curr_d  = '0;
            end
        endcase
        if (adopt_s) begin
            state_d = ST_ACTIVE;
            curr_d  = lnp_q;
        end else begin
            adopt_s = 1'b0;
        end
    end

    // Shadow of the writer's completed pointer, pending flag and counters.
    always_comb begin
        lnp_change_s = onehot_valid(last_next_point) && (last_next_point != lnp_q);
        lnp_d        = lnp_q;
        pending_d    = pending_q;
        skip_d       = skip_q;
        if (adopt_s) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (lnp_change_s) begin
            lnp_d     = last_next_point;
            pending_d = 1'b1;
            // A frame that was pending and not consumed this cycle is lost.
            if (pending_q && !adopt_s && (skip_q != 8'hFF)) begin
                skip_d = skip_q + 8'd1;
            end else begin
                skip_d = skip_q;
            end
        end else begin
            lnp_d = lnp_q;
        end
        if (repeat_inc_s && (repeat_q != 8'hFF)) begin
            repeat_d = repeat_q + 8'd1;
        end else begin
            repeat_d = repeat_q;
        end
        valid_d = (curr_d != '0);
        new_d   = adopt_s;
        addr_d  = BASE_W + (ADDR_W'(onehot2idx(curr_q)) * FRAME_W);
    end

    // State registers; reset releases the held buffer immediately.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            vs_sync1_q <= 1'b0;
            vs_sync2_q <= 1'b0;
            state_q    <= ST_IDLE;
            curr_q     <= '0;
            lnp_q      <= onehot_t'(1);
            pending_q  <= 1'b0;
            repeat_q   <= 8'd0;
            skip_q     <= 8'd0;
            valid_q    <= 1'b0;
            new_q      <= 1'b0;
            addr_q     <= BASE_W;
        end else begin
            vs_sync1_q <= vs_sync1_d;
            vs_sync2_q <= vs_sync2_d;
            state_q    <= state_d;
            curr_q     <= curr_d;
            lnp_q      <= lnp_d;
            pending_q  <= pending_d;
            repeat_q   <= repeat_d;
            skip_q     <= skip_d;
            valid_q    <= valid_d;
            new_q      <= new_d;
            addr_q     <= addr_d;
        end
    end

    assign rd_curr_point  = curr_q;
    assign rd_base_addr   = addr_q;
    assign rd_frame_valid = valid_q;
    assign rd_frame_new   = new_q;
    assign repeat_cnt     = repeat_q;
    assign skip_cnt       = skip_q;

endmodule

// File: tb/tb_baseaddr_rd_loop.sv
// Scoreboard bench for baseaddr_rd_loop: directed scenarios then random
// pointer traffic against a frame-level reference model.
module tb_baseaddr_rd_loop;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam logic [31:0] FRAME = 32'h0020_0000;

    logic        wclk;
    logic        wrst_n;
    logic        rd_vs;
    logic        rd_en;
    logic [4:0]  wr_current_point;
    logic [4:0]  last_next_point;
    logic [4:0]  rd_curr_point;
    logic [31:0] rd_base_addr;
    logic        rd_frame_valid;
    logic        rd_frame_new;
    logic [7:0]  repeat_cnt;
    logic [7:0]  skip_cnt;

    baseaddr_rd_loop #(
        .BASE_ADDR   (BASE),
        .FRAME_BYTES (FRAME),
        .ADDR_W      (32)
    ) dut (
        .wclk             (wclk),
        .wrst_n           (wrst_n),
        .rd_vs            (rd_vs),
        .rd_en            (rd_en),
        .wr_current_point (wr_current_point),
        .last_next_point  (last_next_point),
        .rd_curr_point    (rd_curr_point),
        .rd_base_addr     (rd_base_addr),
        .rd_frame_valid   (rd_frame_valid),
        .rd_frame_new     (rd_frame_new),
        .repeat_cnt       (repeat_cnt),
        .skip_cnt         (skip_cnt)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic [4:0]  pt;
        logic [31:0] addr;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: what the reader holds, the newest completed frame,
    // whether it has been consumed, and the event counters.
    logic [4:0] m_held;
    logic [4:0] m_latest;
    bit         m_unread;
    int         m_repeat;
    int         m_skip;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] addr_of(input logic [4:0] pt);
        return BASE + 32'($clog2(int'(pt))) * FRAME;
    endfunction

    function automatic bit is_onehot(input logic [4:0] v);
        return $countones(v) == 1;
    endfunction

    task automatic model_reset();
        m_held   = 5'b00000;
        m_latest = 5'b00001;
        m_unread = 1'b0;
        m_repeat = 0;
        m_skip   = 0;
        sb_q.delete();
    endtask

    task automatic model_lnp(input logic [4:0] v);
        if (is_onehot(v) && v != m_latest) begin
            if (m_unread && m_skip < 255) m_skip++;
            m_unread = 1'b1;
            m_latest = v;
        end
    endtask

    task automatic model_vsync(input logic en);
        bit fresh;
        exp_t e;
        fresh = m_unread && (m_latest != wr_current_point);
        if (m_held != 5'b00000 && !en) begin
            m_held = 5'b00000;
        end else if (en && fresh) begin
            m_held   = m_latest;
            m_unread = 1'b0;
            e.pt     = m_latest;
            e.addr   = addr_of(m_latest);
            sb_q.push_back(e);
        end else if (m_held != 5'b00000 && m_repeat < 255) begin
            m_repeat++;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_curr"},   32'(rd_curr_point),  32'(m_held));
        chk({tag, "_valid"},  32'(rd_frame_valid), 32'(m_held != 5'b00000));
        chk({tag, "_addr"},   rd_base_addr,        addr_of(m_held));
        chk({tag, "_repeat"}, 32'(repeat_cnt),     32'(m_repeat));
        chk({tag, "_skip"},   32'(skip_cnt),       32'(m_skip));
    endtask

    task automatic set_lnp(input logic [4:0] v);
        @(negedge wclk);
        last_next_point = v;
        model_lnp(v);
        repeat (2) @(negedge wclk);
    endtask

    // Vsync pulse; optional cycle-exact check of the adoption latency.
    task automatic vsync(input logic en, input bit lat_chk, input logic [4:0] lat_pt, input string tag);
        @(negedge wclk);
        rd_en = en;
        model_vsync(en);
        rd_vs = 1'b1;
        if (lat_chk) begin
            for (int i = 1; i <= 4; i++) begin
                @(posedge wclk);
                #1;
                if (i == 3) chk("latency_early", 32'(rd_curr_point), 32'd0);
                if (i == 4) chk("latency_adopt", 32'(rd_curr_point), 32'(lat_pt));
            end
            repeat (1) @(negedge wclk);
        end else begin
            repeat (4) @(negedge wclk);
        end
        rd_vs = 1'b0;
        repeat (6) @(negedge wclk);
        check_state(tag);
    endtask

    // Monitor: every adoption pulse must match the next queued expectation,
    // and the base address must follow one cycle later.
    initial begin
        bit          addr_due;
        logic [31:0] exp_addr;
        exp_t        e;
        addr_due = 1'b0;
        exp_addr = 32'd0;
        forever begin
            @(negedge wclk);
            if (!wrst_n) begin
                addr_due = 1'b0;
            end else begin
                if (addr_due) begin
                    chk("mon_base_addr", rd_base_addr, exp_addr);
                    addr_due = 1'b0;
                end
                if (rd_frame_new === 1'b1) begin
                    if (sb_q.size() == 0) begin
                        chk("mon_frame_new_unexpected", 32'd1, 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        chk("mon_adopt_point", 32'(rd_curr_point), 32'(e.pt));
                        chk("mon_adopt_valid", 32'(rd_frame_valid), 32'd1);
                        exp_addr = e.addr;
                        addr_due = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        logic [4:0] v;
        wrst_n           = 1'b0;
        rd_vs            = 1'b0;
        rd_en            = 1'b1;
        wr_current_point = 5'b00001;
        last_next_point  = 5'b00001;
        model_reset();
        repeat (3) @(negedge wclk);
        check_state("reset");
        chk("reset_new", 32'(rd_frame_new), 32'd0);
        wrst_n = 1'b1;

        // Post-reset default pointer is not a frame.
        vsync(1'b1, 1'b0, 5'b0, "idle");

        // Basic adoption with latency check.
        wr_current_point = 5'b01000;
        set_lnp(5'b00100);
        vsync(1'b1, 1'b1, 5'b00100, "adopt");
        chk("adopt_addr_abs", rd_base_addr, BASE + 32'h0040_0000);

        // Repeats with no new frame.
        for (int i = 0; i < 3; i++) vsync(1'b1, 1'b0, 5'b0, "repeat");
        chk("repeat_three", 32'(repeat_cnt), 32'd3);

        // Two completions between vsyncs: one skipped.
        set_lnp(5'b01000);
        set_lnp(5'b10000);
        vsync(1'b1, 1'b0, 5'b0, "skip");
        chk("skip_one", 32'(skip_cnt), 32'd1);
        chk("skip_point", 32'(rd_curr_point), 32'b10000);

        // Collision guard, then adoption once the writer moves on.
        wr_current_point = 5'b00010;
        set_lnp(5'b00010);
        vsync(1'b1, 1'b0, 5'b0, "collide");
        chk("collide_held", 32'(rd_curr_point), 32'b10000);
        wr_current_point = 5'b00100;
        vsync(1'b1, 1'b0, 5'b0, "collide_after");
        chk("collide_adopt", 32'(rd_curr_point), 32'b00010);

        // Non-one-hot completion pointer is ignored.
        set_lnp(5'b00110);
        vsync(1'b1, 1'b0, 5'b0, "bad_onehot");

        // Release on disabled vsync.
        vsync(1'b0, 1'b0, 5'b0, "release");
        chk("release_zero", 32'(rd_curr_point), 32'd0);

        // Re-adopt, then asynchronous reset mid-frame.
        set_lnp(5'b10000);
        vsync(1'b1, 1'b0, 5'b0, "readopt");
        @(posedge wclk);
        #3;
        wrst_n          = 1'b0;
        last_next_point = 5'b00001;
        #1;
        chk("arst_queue_empty", 32'(sb_q.size()), 32'd0);
        model_reset();
        check_state("arst");
        chk("arst_new", 32'(rd_frame_new), 32'd0);
        repeat (2) @(negedge wclk);
        wrst_n = 1'b1;

        // Random traffic.
        for (int it = 0; it < 150; it++) begin
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                if ($urandom_range(0, 9) < 7) v = 5'(1 << $urandom_range(0, 4));
                else v = 5'($urandom_range(0, 31));
                set_lnp(v);
            end
            @(negedge wclk);
            wr_current_point = 5'(1 << $urandom_range(0, 4));
            vsync(($urandom_range(0, 9) != 0), 1'b0, 5'b0, "rand");
        end

        repeat (4) @(negedge wclk);
        chk("final_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
